dmem_resp: RTL and testbench

Responder end of the data-memory load/store interface: accepts one load or store request at a time from the pipeline's memory stage over a valid/ready handshake and returns a response over a second valid/ready handshake. It owns the data RAM and resolves byte accesses and misaligned word accesses internally, splitting them into multiple RAM cycles. It replaces direct combinational RAM access so that misalignment stalls are paid inside the responder rather than in the pipeline.

---
 rtl/dmem_resp.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_resp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: owns the data RAM and serves one load/store
// at a time, splitting byte and misaligned word accesses into RAM cycles.
module dmem_resp #(
  parameter int AW = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ReqVal,
  output logic        ReqRdy,
  input  logic        ReqWr,
  input  logic        ReqByte,
  input  logic [31:0] ReqAdr,
  input  logic [31:0] ReqWrDat,
  output logic        RspVal,
  input  logic        RspRdy,
  output logic [31:0] RspRdDat,
  output logic [15:0] ReqCnt,
  output logic [15:0] SplitCnt
);

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    WR0,
    WR1,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic          wr_q, wr_d;
  logic          byte_q, byte_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] a_q, a_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   w0_q, w0_d;
  logic [31:0]   w1_q, w1_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [15:0]   req_cnt_q, req_cnt_d;
  logic [15:0]   split_cnt_q, split_cnt_d;

  logic [31:0]   mem [2**AW];

  logic [AW-1:0] a1;
  logic [31:0]   rd0, rd1;
  logic [4:0]    sh, bsh;
  logic          mis;
  logic [7:0]    bv;
  logic [63:0]   ld64, mask64, data64, mrg;
  logic [31:0]   bmask, bdat, bmrg;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [31:0]   ram_wd;
  logic          unused_adr;

  assign unused_adr = ^ReqAdr[31:AW+2];

  assign a1  = a_q + {{(AW-1){1'b0}}, 1'b1};
  assign rd0 = mem[a_q];
  assign rd1 = mem[a1];
  assign sh  = {off_q, 3'b000};
  assign bsh = {~off_q, 3'b000};
  assign mis = !byte_q && (off_q != 2'd0);
  assign bv  = 8'(rd0 >> bsh);

  // big-endian: byte 0 sits in the top lane, so shifting left walks forward
  assign ld64   = {w0_q, rd1} << sh;
  assign mask64 = 64'hFFFF_FFFF_0000_0000 >> sh;
  assign data64 = {wdat_q, 32'h0} >> sh;
  assign mrg    = ({w0_q, w1_q} & ~mask64) | data64;
  assign bmask  = 32'hFF00_0000 >> sh;
  assign bdat   = {wdat_q[7:0], 24'h0} >> sh;
  assign bmrg   = (w0_q & ~bmask) | bdat;

  always_comb begin
    ram_we = 1'b0;
    ram_wa = a_q;
    ram_wd = mrg[63:32];
    unique case (1'b1)
      (state_q == WR0) && byte_q: begin
        ram_we = 1'b1;
        ram_wd = bmrg;
      end
      (state_q == WR0) && !byte_q: begin
        ram_we = 1'b1;
      end
      (state_q == WR1): begin
        ram_we = 1'b1;
        ram_wa = a1;
        ram_wd = mrg[31:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_wd;
  end

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    byte_d      = byte_q;
    off_d       = off_q;
    a_d         = a_q;
    wdat_d      = wdat_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    rdat_d      = rdat_q;
    req_cnt_d   = req_cnt_q;
    split_cnt_d = split_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ReqVal) begin
          wr_d      = ReqWr;
          byte_d    = ReqByte;
          off_d     = ReqAdr[1:0];
          a_d       = ReqAdr[AW+1:2];
          wdat_d    = ReqWrDat;
          req_cnt_d = req_cnt_q + 16'd1;
          if (!ReqByte && ReqAdr[1:0] != 2'd0)
            split_cnt_d = split_cnt_q + 16'd1;
          if (ReqWr && !ReqByte && ReqAdr[1:0] == 2'd0)
            state_d = WR0;
          else
            state_d = RD0;
        end
      end
      RD0: begin
        w0_d = rd0;
        if (!wr_q && byte_q) begin
          rdat_d  = {{24{bv[7]}}, bv};
          state_d = RESP;
        end else if (!wr_q && !mis) begin
          rdat_d  = rd0;
          state_d = RESP;
        end else if (wr_q && byte_q) begin
          state_d = WR0;
        end else begin
          state_d = RD1;
        end
      end
      RD1: begin
        w1_d = rd1;
        if (wr_q) begin
          state_d = WR0;
        end else begin
          rdat_d  = ld64[63:32];
          state_d = RESP;
        end
      end
      WR0: begin
        rdat_d  = 32'h0;
        state_d = mis ? WR1 : RESP;
      end
      WR1: begin
        rdat_d  = 32'h0;
        state_d = RESP;
      end
      RESP: begin
        if (RspRdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      off_q       <= 2'd0;
      a_q         <= '0;
      wdat_q      <= 32'h0;
      w0_q        <= 32'h0;
      w1_q        <= 32'h0;
      rdat_q      <= 32'h0;
      req_cnt_q   <= 16'h0;
      split_cnt_q <= 16'h0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      off_q       <= off_d;
      a_q         <= a_d;
      wdat_q      <= wdat_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      rdat_q      <= rdat_d;
      req_cnt_q   <= req_cnt_d;
      split_cnt_q <= split_cnt_d;
    end
  end

  assign ReqRdy   = (state_q == IDLE);
  assign RspVal   = (state_q == RESP);
  assign RspRdDat = rdat_q;
  assign ReqCnt   = req_cnt_q;
  assign SplitCnt = split_cnt_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: aligned, misaligned, byte, wrap,
// backpressure and mid-operation reset cases.
module tb_dmem_resp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ReqVal, ReqRdy, ReqWr, ReqByte;
  logic [31:0] ReqAdr, ReqWrDat;
  logic        RspVal, RspRdy;
  logic [31:0] RspRdDat;
  logic [15:0] ReqCnt, SplitCnt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_resp #(.AW(6)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ReqVal   (ReqVal),
    .ReqRdy   (ReqRdy),
    .ReqWr    (ReqWr),
    .ReqByte  (ReqByte),
    .ReqAdr   (ReqAdr),
    .ReqWrDat (ReqWrDat),
    .RspVal   (RspVal),
    .RspRdy   (RspRdy),
    .RspRdDat (RspRdDat),
    .ReqCnt   (ReqCnt),
    .SplitCnt (SplitCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  // issue one request, wait for its response and complete it
  task automatic do_req(input bit wr, input bit bt,
                        input logic [31:0] adr, input logic [31:0] dat,
                        output logic [31:0] rd, output int lat);
    int n;
    @(negedge clk);
    ReqVal   = 1'b1;
    ReqWr    = wr;
    ReqByte  = bt;
    ReqAdr   = adr;
    ReqWrDat = dat;
    RspRdy   = 1'b1;
    n = 0;
    while (!ReqRdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    ReqVal = 1'b0;
    lat = 0;
    while (!RspVal && lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
    end
    lat = lat + 1;
    rd = RspRdDat;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rd, held;
  int lat;

  initial begin
    reset_n  = 1'b0;
    ReqVal   = 1'b0;
    ReqWr    = 1'b0;
    ReqByte  = 1'b0;
    ReqAdr   = 32'h0;
    ReqWrDat = 32'h0;
    RspRdy   = 1'b0;
    #12;
    chk("rst_reqrdy", {31'h0, ReqRdy}, 32'h1);
    chk("rst_rspval", {31'h0, RspVal}, 32'h0);
    chk("rst_rdat", RspRdDat, 32'h0);
    chk("rst_reqcnt", {16'h0, ReqCnt}, 32'h0);
    chk("rst_splitcnt", {16'h0, SplitCnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    do_req(1, 0, 32'h10, 32'h11223344, rd, lat);
    chk("st_al_lat", lat, 2);
    chk("st_al_rdat", rd, 32'h0);
    do_req(0, 0, 32'h10, 32'h0, rd, lat);
    chk("ld_al_lat", lat, 2);
    chk("ld_al_dat", rd, 32'h11223344);
    chk("cnt_a", {16'h0, ReqCnt}, 32'd2);
    chk("split_a", {16'h0, SplitCnt}, 32'd0);

    do_req(1, 0, 32'h10, 32'hAABBCCDD, rd, lat);
    do_req(1, 0, 32'h14, 32'h11223344, rd, lat);
    do_req(0, 0, 32'h11, 32'h0, rd, lat);
    chk("ld_mis1_lat", lat, 3);
    chk("ld_mis1_dat", rd, 32'hBBCCDD11);
    do_req(0, 0, 32'h13, 32'h0, rd, lat);
    chk("ld_mis3_dat", rd, 32'hDD112233);
    chk("cnt_b", {16'h0, ReqCnt}, 32'd6);
    chk("split_b", {16'h0, SplitCnt}, 32'd2);

    do_req(1, 0, 32'h08, 32'h0, rd, lat);
    do_req(1, 1, 32'h0A, 32'h123456FF, rd, lat);
    chk("st_b_lat", lat, 3);
    do_req(0, 0, 32'h08, 32'h0, rd, lat);
    chk("st_b_word", rd, 32'h0000FF00);
    do_req(0, 1, 32'h0A, 32'h0, rd, lat);
    chk("ld_b_lat", lat, 2);
    chk("ld_b_neg", rd, 32'hFFFFFFFF);
    do_req(0, 1, 32'h0B, 32'h0, rd, lat);
    chk("ld_b_zero", rd, 32'h0);
    chk("split_c", {16'h0, SplitCnt}, 32'd2);

    do_req(1, 0, 32'hFC, 32'h0, rd, lat);
    do_req(1, 0, 32'h00, 32'h0, rd, lat);
    do_req(1, 0, 32'hFE, 32'hCAFEBABE, rd, lat);
    chk("st_mis_lat", lat, 5);
    chk("st_mis_rdat", rd, 32'h0);
    do_req(0, 0, 32'hFC, 32'h0, rd, lat);
    chk("st_wrap_w63", rd, 32'h0000CAFE);
    do_req(0, 0, 32'h00, 32'h0, rd, lat);
    chk("st_wrap_w0", rd, 32'hBABE0000);
    do_req(0, 0, 32'hFE, 32'h0, rd, lat);
    chk("ld_wrap", rd, 32'hCAFEBABE);
    chk("cnt_d", {16'h0, ReqCnt}, 32'd17);
    chk("split_d", {16'h0, SplitCnt}, 32'd4);

    // backpressure on an aligned load of 0x10 (0xAABBCCDD)
    @(negedge clk);
    ReqVal  = 1'b1;
    ReqWr   = 1'b0;
    ReqByte = 1'b0;
    ReqAdr  = 32'h10;
    RspRdy  = 1'b0;
    @(posedge clk);
    #1;
    ReqVal = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_val0", {31'h0, RspVal}, 32'h1);
    chk("bp_dat0", RspRdDat, 32'hAABBCCDD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ReqVal = (i == 1);
      ReqAdr = 32'h3C;
      chk("bp_val", {31'h0, RspVal}, 32'h1);
      chk("bp_dat", RspRdDat, 32'hAABBCCDD);
      chk("bp_reqrdy", {31'h0, ReqRdy}, 32'h0);
    end
    @(negedge clk);
    ReqVal = 1'b0;
    chk("bp_cnt", {16'h0, ReqCnt}, 32'd18);
    RspRdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_done_rdy", {31'h0, ReqRdy}, 32'h1);
    chk("bp_done_val", {31'h0, RspVal}, 32'h0);

    // reset during WR1 of a misaligned store
    do_req(1, 0, 32'h28, 32'h01020304, rd, lat);
    do_req(1, 0, 32'h2C, 32'h05060708, rd, lat);
    @(negedge clk);
    ReqVal   = 1'b1;
    ReqWr    = 1'b1;
    ReqByte  = 1'b0;
    ReqAdr   = 32'h29;
    ReqWrDat = 32'hA1A2A3A4;
    @(posedge clk);
    #1;
    ReqVal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_val", {31'h0, RspVal}, 32'h0);
    reset_n = 1'b0;
    #1;
    chk("mid_rspval", {31'h0, RspVal}, 32'h0);
    chk("mid_reqrdy", {31'h0, ReqRdy}, 32'h1);
    chk("mid_reqcnt", {16'h0, ReqCnt}, 32'h0);
    chk("mid_split", {16'h0, SplitCnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    do_req(0, 0, 32'h28, 32'h0, rd, lat);
    chk("mid_w0", rd, 32'h01A1A2A3);
    do_req(0, 0, 32'h2C, 32'h0, rd, lat);
    chk("mid_w1", rd, 32'h05060708);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
